// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_if
// Description : Parallel-side bundle of the SPI responder: RX stream out of
//               the FIFO, TX reply stream into the holding buffer, status
//               flags and the flag-clear strobe.
//               slave  modport - seen by spi_slave
//               master modport - seen by the loader logic driving it
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_if #(
    parameter int BIT     = 8,
    parameter int FIFO_AW = 2
);
    logic [BIT-1:0]   rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [FIFO_AW:0] rx_count;
    logic [BIT-1:0]   tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             overrun;
    logic             underrun;
    logic             err_clr;

    modport slave (
        output rx_data, rx_valid, rx_count, tx_ready, busy, overrun, underrun,
        input  rx_ready, tx_data, tx_valid, err_clr
    );

    modport master (
        input  rx_data, rx_valid, rx_count, tx_ready, busy, overrun, underrun,
        output rx_ready, tx_data, tx_valid, err_clr
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave
// Description : SPI mode-0 responder, MSB first. SPI pins are oversampled in
//               the clk domain. Received words go to a first-word fall-through
//               RX FIFO; reply words come from a one-entry TX holding buffer
//               (TX_IDLE is sent, and underrun flagged, when it is empty).
// Ports       : clk, rstn (sync, active low)
//               bus       - spi_slave_if.slave (rx/tx streams, status, err_clr)
//               SPI_CLK, SPI_CS, SPI_MOSI - asynchronous SPI inputs
//               SPI_MISO  - slave-out data
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int             BIT        = 8,
    parameter int             FIFO_DEPTH = 4,
    parameter int             FIFO_AW    = 2,
    parameter logic [BIT-1:0] TX_IDLE    = BIT'(8'hFF)
) (
    input  wire logic  clk,
    input  wire logic  rstn,
    spi_slave_if.slave bus,
    input  wire logic  SPI_CLK,
    input  wire logic  SPI_CS,
    input  wire logic  SPI_MOSI,
    output logic       SPI_MISO
);
    localparam int CNT_W = $clog2(BIT);
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    // Synchroniser chains: [0],[1] = 2-FF sync, [2] = previous value for edges.
    // The CS chain resets low so a frame already in progress at reset release
    // does not look like a fresh CS falling edge.
    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SPI_CLK};
            cs_sync   <= {cs_sync[1:0], SPI_CS};
            mosi_sync <= {mosi_sync[0], SPI_MOSI};
        end
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];

    logic [0:0]     state;
    logic [CNT_W-1:0] bit_cnt;
    logic [BIT-1:0] shift_in;
    logic [BIT-1:0] shift_out;
    logic           reload;
    logic           word_done;
    logic [BIT-1:0] word;

    logic [BIT-1:0] tx_buf;
    logic           tx_full;
    logic           overrun;
    logic           underrun;

    // Shift-out load: at frame start, or on the first SCLK fall after a word.
    // A CS rise in the same cycle ends the frame, so no load happens then.
    logic           load;
    logic [BIT-1:0] load_word;
    assign load = ~cs_rise &
                  (((state == S_IDLE) & cs_fall) |
                   ((state == S_ACTIVE) & sclk_fall & reload));
    assign load_word = tx_full ? tx_buf : TX_IDLE;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            reload    <= 1'b0;
            word_done <= 1'b0;
            word      <= '0;
            SPI_MISO  <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (cs_rise) begin
                state    <= S_IDLE;
                bit_cnt  <= '0;
                reload   <= 1'b0;
                SPI_MISO <= 1'b0;
            end else if (state == S_IDLE) begin
                if (cs_fall) begin
                    state     <= S_ACTIVE;
                    bit_cnt   <= '0;
                    reload    <= 1'b0;
                    shift_out <= load_word;
                    SPI_MISO  <= load_word[BIT-1];
                end
            end else begin
                if (sclk_rise) begin
                    shift_in <= {shift_in[BIT-2:0], mosi_sync[1]};
                    if (bit_cnt == CNT_W'(BIT-1)) begin
                        // Word complete: hand it to the FIFO stage next clk
                        word_done <= 1'b1;
                        word      <= {shift_in[BIT-2:0], mosi_sync[1]};
                        bit_cnt   <= '0;
                        reload    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (reload) begin
                        shift_out <= load_word;
                        SPI_MISO  <= load_word[BIT-1];
                        reload    <= 1'b0;
                    end else begin
                        shift_out <= {shift_out[BIT-2:0], 1'b0};
                        SPI_MISO  <= shift_out[BIT-2];
                    end
                end
            end
        end
    end

    // RX FIFO (first-word fall-through)
    logic [BIT-1:0]   mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0] count;
    logic             full, pop, push;

    assign full = (count == (FIFO_AW+1)'(FIFO_DEPTH));
    assign pop  = (count != '0) & bus.rx_ready;
    // When full, a simultaneous pop frees the slot the push overwrites
    assign push = word_done & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~push) begin
                count <= count - 1'b1;
            end
        end
    end

    // TX holding buffer and sticky flags (a set beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_buf   <= '0;
            tx_full  <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (bus.tx_valid & ~tx_full) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end else if (load) begin
                tx_full <= 1'b0;
            end

            if (word_done & full & ~pop) begin
                overrun <= 1'b1;
            end else if (bus.err_clr) begin
                overrun <= 1'b0;
            end

            if (load & ~tx_full) begin
                underrun <= 1'b1;
            end else if (bus.err_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    assign bus.rx_data  = mem[rd_ptr];
    assign bus.rx_valid = (count != '0);
    assign bus.rx_count = count;
    assign bus.tx_ready = ~tx_full;
    assign bus.busy     = (state == S_ACTIVE);
    assign bus.overrun  = overrun;
    assign bus.underrun = underrun;
endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave
// Description : Directed self-checking bench for spi_slave. A bit-banged
//               SPI master (SCLK low/high 4 clk each) drives frames; the
//               loader side pops the RX FIFO and writes the TX buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;
    logic clk;
    logic rstn;
    logic sclk, cs, mosi, miso;
    int   checks;
    int   errors;

    spi_slave_if #(.BIT(8), .FIFO_AW(2)) bus ();

    spi_slave #(
        .BIT(8), .FIFO_DEPTH(4), .FIFO_AW(2), .TX_IDLE(8'hFF)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .SPI_CLK(sclk), .SPI_CS(cs), .SPI_MOSI(mosi), .SPI_MISO(miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cs_start();
        cs = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_in_frame", 32'(bus.busy), 32'd1);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // mode 1: check rx_valid push latency on the last bit (empty FIFO)
    // mode 2: pulse rx_ready on the exact cycle the word is pushed
    task automatic xfer(input logic [7:0] mo, input int nbits, input int mode,
                        input logic wr_en, input logic [7:0] wr_word,
                        input logic hold, input logic [7:0] pop_exp,
                        output logic [7:0] mi);
        mi = '0;
        for (int n = 0; n < nbits; n++) begin
            int i;
            i = 7 - n;
            mosi = mo[i];
            if (wr_en && n == 3) begin
                chk("tx_ready_before_write", 32'(bus.tx_ready), 32'd1);
                bus.tx_data  = wr_word;
                bus.tx_valid = 1'b1;
                @(negedge clk);
                bus.tx_valid = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            mi[i] = miso;
            sclk = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (mode == 2 && n == 7 && k == 3) begin
                    chk("head_before_pop", 32'(bus.rx_data), 32'(pop_exp));
                    bus.rx_ready = 1'b1;
                end
                @(negedge clk);
                bus.rx_ready = 1'b0;
                if (mode == 1 && n == 7 && k == 2)
                    chk("rx_valid_before_push", 32'(bus.rx_valid), 32'd0);
                if (mode == 1 && n == 7 && k == 3)
                    chk("rx_valid_after_push", 32'(bus.rx_valid), 32'd1);
            end
            if (!(hold && n == nbits - 1)) sclk = 1'b0;
        end
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(bus.rx_data), 32'(exp));
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] mi;
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        bus.rx_ready = 1'b0; bus.tx_data = '0; bus.tx_valid = 1'b0; bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Reset values
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_rx_count", 32'(bus.rx_count), 32'd0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_underrun", 32'(bus.underrun), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);

        // 1: single word, TX empty
        cs_start();
        xfer(8'hA5, 8, 1, 1'b0, 8'h00, 1'b1, 8'h00, mi);
        cs_end();
        chk("t1_miso", 32'(mi), 32'hFF);
        chk("t1_count", 32'(bus.rx_count), 32'd1);
        chk("t1_underrun", 32'(bus.underrun), 32'd1);
        chk("t1_busy_after", 32'(bus.busy), 32'd0);
        pop("t1_pop", 8'hA5);
        clear_err();
        chk("t1_underrun_clr", 32'(bus.underrun), 32'd0);

        // 2: preloaded reply plus a reply written during word 1
        bus.tx_data = 8'h3C; bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        @(negedge clk);
        chk("t2_tx_ready_full", 32'(bus.tx_ready), 32'd0);
        cs_start();
        xfer(8'h12, 8, 0, 1'b1, 8'hC3, 1'b0, 8'h00, mi);
        chk("t2_miso_w1", 32'(mi), 32'h3C);
        xfer(8'h34, 8, 0, 1'b0, 8'h00, 1'b1, 8'h00, mi);
        chk("t2_miso_w2", 32'(mi), 32'hC3);
        cs_end();
        chk("t2_underrun", 32'(bus.underrun), 32'd0);
        chk("t2_tx_ready", 32'(bus.tx_ready), 32'd1);
        pop("t2_pop1", 8'h12);
        pop("t2_pop2", 8'h34);

        // 3: overrun with 5 words, FIFO depth 4
        cs_start();
        for (int w = 1; w <= 5; w++)
            xfer(8'(w), 8, 0, 1'b0, 8'h00, (w == 5), 8'h00, mi);
        cs_end();
        chk("t3_count", 32'(bus.rx_count), 32'd4);
        chk("t3_overrun", 32'(bus.overrun), 32'd1);
        for (int w = 1; w <= 4; w++) pop("t3_pop", 8'(w));
        chk("t3_empty", 32'(bus.rx_valid), 32'd0);
        clear_err();
        chk("t3_overrun_clr", 32'(bus.overrun), 32'd0);
        chk("t3_underrun_clr", 32'(bus.underrun), 32'd0);

        // 4: push and pop on the same cycle while full
        cs_start();
        xfer(8'h11, 8, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi);
        xfer(8'h22, 8, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi);
        xfer(8'h33, 8, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi);
        xfer(8'h44, 8, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi);
        chk("t4_full", 32'(bus.rx_count), 32'd4);
        xfer(8'h55, 8, 2, 1'b0, 8'h00, 1'b1, 8'h11, mi);
        chk("t4_count_same", 32'(bus.rx_count), 32'd4);
        cs_end();
        chk("t4_overrun", 32'(bus.overrun), 32'd0);
        chk("t4_count", 32'(bus.rx_count), 32'd4);
        pop("t4_pop", 8'h22);
        pop("t4_pop", 8'h33);
        pop("t4_pop", 8'h44);
        pop("t4_pop", 8'h55);

        // 5: aborted partial word then a full frame
        cs_start();
        xfer(8'hFF, 5, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi);
        cs_end();
        chk("t5_no_partial", 32'(bus.rx_count), 32'd0);
        cs_start();
        xfer(8'h81, 8, 0, 1'b0, 8'h00, 1'b1, 8'h00, mi);
        cs_end();
        chk("t5_count", 32'(bus.rx_count), 32'd1);
        pop("t5_pop", 8'h81);

        // 6: reset in the middle of a word
        cs_start();
        xfer(8'hFF, 3, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_underrun", 32'(bus.underrun), 32'd0);
        chk("t6_rst_miso", 32'(miso), 32'd0);
        chk("t6_rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        chk("t6_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        xfer(8'hFF, 5, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi);
        chk("t6_ignored_busy", 32'(bus.busy), 32'd0);
        cs_end();
        chk("t6_ignored_count", 32'(bus.rx_count), 32'd0);
        cs_start();
        xfer(8'h5A, 8, 0, 1'b0, 8'h00, 1'b1, 8'h00, mi);
        cs_end();
        chk("t6_count", 32'(bus.rx_count), 32'd1);
        pop("t6_pop", 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
